// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial test-sequence generator.
// Holds the FSM state encoding and the default pattern width, length-port
// width and LFSR feedback mask used by serial_seq_gen and seq_gen_shreg.
package seq_gen_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned LEN_W_DEF = 4;
  localparam logic [7:0]  TAPS_DEF  = 8'b1011_1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_gen_shreg.sv
// W-bit load/shift register for the sequence generator.
// Build option: SEQ_GEN_LFSR_EN adds Fibonacci LFSR feedback (lfsr input, TAPS).
// Ports:
//   clk, rst   clock (rising) and asynchronous active-high reset (clears register)
//   load       load din this edge (priority over shift)
//   shift      shift left one bit this edge
//   lfsr       (SEQ_GEN_LFSR_EN only) LFSR feedback on shift, zero seed becomes 1
//   din        parallel load value
//   msb_n_c    MSB of the value the register takes at the next edge
module seq_gen_shreg
  import seq_gen_pkg::*;
#(
  parameter int unsigned W = W_DEF
`ifdef SEQ_GEN_LFSR_EN
  , parameter logic [W-1:0] TAPS = W'(TAPS_DEF)
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
`ifdef SEQ_GEN_LFSR_EN
  input  logic         lfsr,
`endif
  input  logic [W-1:0] din,
  output logic         msb_n_c
);

  logic [W-1:0] q;
  logic [W-1:0] d;

  // Next-value selection: hold, load or shift.
  always_comb begin
    d = q;
    if (load) begin
      d = din;
`ifdef SEQ_GEN_LFSR_EN
      // An all-zero LFSR would lock up; seed with 1 instead.
      if (lfsr && (din == '0)) d = W'(1);
`endif
    end else if (shift) begin
      d = {q[W-2:0], 1'b0};
`ifdef SEQ_GEN_LFSR_EN
      if (lfsr) d = {q[W-2:0], ^(q & TAPS)};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

  // Exposed so the parent can register x in the same cycle as the shift.
  assign msb_n_c = d[W-1];

endmodule

// File: rtl/serial_seq_gen.sv
// Serial test-sequence transmitter: shifts a programmed pattern out on x,
// MSB first, one bit per cp edge, with start/busy/done handshake and
// optional automatic repeat.
// Build option: SEQ_GEN_LFSR_EN adds the lfsr_mode input (LFSR sequence mode).
// Ports:
//   cp         clock, rising edge
//   rd         asynchronous active-high reset
//   start      request transmission (sampled in IDLE only)
//   pat        pattern, MSB sent first (LFSR seed in LFSR mode)
//   len        bits per pass, 1..W (larger values clamp to W, 0 ignored)
//   rep        restart the pass automatically at its end (sampled with start)
//   stop       abort transmission, no done pulse
//   lfsr_mode  (SEQ_GEN_LFSR_EN only) LFSR sequence instead of pattern
//   x          serial bit, 0 when x_vld is low
//   x_vld      x carries a pattern bit this cycle
//   busy       high while shifting
//   done       one-cycle pulse after the last bit of a non-repeating pass
module serial_seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
`ifdef SEQ_GEN_LFSR_EN
  , parameter logic [W-1:0] TAPS = W'(TAPS_DEF)
`endif
) (
  input  logic             cp,
  input  logic             rd,
  input  logic             start,
  input  logic [W-1:0]     pat,
  input  logic [LEN_W-1:0] len,
  input  logic             rep,
  input  logic             stop,
`ifdef SEQ_GEN_LFSR_EN
  input  logic             lfsr_mode,
`endif
  output logic             x,
  output logic             x_vld,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] W_LEN = LEN_W'(W);

  state_t             state, state_n;
  logic [LEN_W-1:0]   cnt, cnt_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [W-1:0]       pat_q, pat_n;
  logic               rep_q, rep_n;
  logic               ld, sh;
  logic [W-1:0]       ld_val;
  logic               msb_n_c;
`ifdef SEQ_GEN_LFSR_EN
  logic               lfsr_q, lfsr_n;
`endif

  // Next-state, counter and shift-register control.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len_q;
    pat_n   = pat_q;
    rep_n   = rep_q;
    ld      = 1'b0;
    sh      = 1'b0;
    ld_val  = pat_q;
`ifdef SEQ_GEN_LFSR_EN
    lfsr_n  = lfsr_q;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_n = ST_SHIFT;
          len_n   = (len > W_LEN) ? W_LEN : len;
          cnt_n   = (len > W_LEN) ? W_LEN : len;
          pat_n   = pat;
          rep_n   = rep;
          ld      = 1'b1;
          ld_val  = pat;
`ifdef SEQ_GEN_LFSR_EN
          lfsr_n  = lfsr_mode;
`endif
        end
      end
      ST_SHIFT: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (cnt == LEN_W'(1)) begin
          if (rep_q) begin
            // Seamless restart: next pass begins on the very next bit.
            cnt_n = len_q;
            ld    = 1'b1;
`ifdef SEQ_GEN_LFSR_EN
            // LFSR mode keeps running rather than reseeding.
            if (lfsr_q) begin
              ld = 1'b0;
              sh = 1'b1;
            end
`endif
          end else begin
            state_n = ST_DONE;
            sh      = 1'b1;
          end
        end else begin
          sh    = 1'b1;
          cnt_n = cnt - LEN_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  seq_gen_shreg #(
    .W    (W)
`ifdef SEQ_GEN_LFSR_EN
    , .TAPS (TAPS)
`endif
  ) u_shreg (
    .clk     (cp),
    .rst     (rd),
    .load    (ld),
    .shift   (sh),
`ifdef SEQ_GEN_LFSR_EN
    .lfsr    (lfsr_n),
`endif
    .din     (ld_val),
    .msb_n_c (msb_n_c)
  );

  // State, latched request and registered outputs.
  always_ff @(posedge cp or posedge rd) begin
    if (rd) begin
      state <= ST_IDLE;
      cnt   <= '0;
      len_q <= '0;
      pat_q <= '0;
      rep_q <= 1'b0;
`ifdef SEQ_GEN_LFSR_EN
      lfsr_q <= 1'b0;
`endif
      x     <= 1'b0;
      x_vld <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      len_q <= len_n;
      pat_q <= pat_n;
      rep_q <= rep_n;
`ifdef SEQ_GEN_LFSR_EN
      lfsr_q <= lfsr_n;
`endif
      x     <= (state_n == ST_SHIFT) & msb_n_c;
      x_vld <= (state_n == ST_SHIFT);
      busy  <= (state_n == ST_SHIFT);
      done  <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_serial_seq_gen.sv
// Self-checking bench for serial_seq_gen (W=8, pattern mode).
// The driver issues passes and pushes the expected output cycles into a queue;
// a monitor compares every cycle's outputs against the queue head or idle.
module tb_serial_seq_gen;

  logic       cp;
  logic       rd;
  logic       start;
  logic [7:0] pat;
  logic [3:0] len;
  logic       rep;
  logic       stop;
  logic       lfsr_mode;
  logic       x, x_vld, busy, done;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [3:0]  exp_q[$];
  logic [3:0]  act;
  logic [3:0]  exp_v;

  serial_seq_gen dut (
    .cp        (cp),
    .rd        (rd),
    .start     (start),
    .pat       (pat),
    .len       (len),
    .rep       (rep),
    .stop      (stop),
`ifdef SEQ_GEN_LFSR_EN
    .lfsr_mode (lfsr_mode),
`endif
    .x         (x),
    .x_vld     (x_vld),
    .busy      (busy),
    .done      (done)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic check(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Outputs as {x, x_vld, busy, done}: shifting bit b -> {b,1,1,0}, done -> 0001.
  always @(negedge cp) begin
    if (!rd) begin
      act = {x, x_vld, busy, done};
      if (x_vld || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", int'(act), 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("out", int'(act), int'(exp_v));
        end
      end else begin
        check("idle", int'(act), 0);
      end
    end
  end

  // One request, issued at a negedge. m>0: stop driven so that m bits emerge.
  // Extra start pulses and input changes while busy must have no effect.
  task automatic run_pass(input logic [7:0] p, input logic [3:0] l,
                          input logic r, input int m);
    int n;
    int total;
    int cycles;
    logic b;
    n = (l > 4'd8) ? 8 : int'(l);
    start = 1'b1; pat = p; len = l; rep = r; stop = 1'b0;
    if (n == 0) begin
      @(negedge cp);
      start = 1'b0;
      return;
    end
    total = (m > 0) ? m : n;
    for (int j = 0; j < total; j++) begin
      b = p[7 - (j % n)];
      exp_q.push_back({b, 3'b110});
    end
    if (m == 0) exp_q.push_back(4'b0001);
    cycles = (m > 0) ? m : n + 1;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge cp);
      start = 1'($urandom_range(0, 1));
      pat   = 8'($urandom);
      len   = 4'($urandom);
      rep   = 1'($urandom);
      if (m > 0 && c == m) stop = 1'b1;
    end
    @(negedge cp);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int m;
    int n;
    logic [3:0] l;
    logic r;
    n_cmp = 0; n_err = 0;
    rd = 1'b1; start = 1'b0; pat = '0; len = '0; rep = 1'b0; stop = 1'b0;
    lfsr_mode = 1'b0;
    #1;
    check("reset_outputs", int'({x, x_vld, busy, done}), 0);
    @(posedge cp); #2 rd = 1'b0;
    @(negedge cp);

    // Single full pass, repeating short pattern with stop, ignored/clamped lengths.
    run_pass(8'b1011_0010, 4'd8, 1'b0, 0);
    run_pass(8'b1100_0000, 4'd3, 1'b1, 9);
    run_pass(8'h5a, 4'd0, 1'b0, 0);
    repeat (3) @(negedge cp);
    run_pass(8'b1110_0101, 4'd12, 1'b0, 0);
    run_pass(8'b0110_1001, 4'd1, 1'b0, 0);
    run_pass(8'b1001_0110, 4'd4, 1'b0, 4);

    // Asynchronous reset during the 4th bit, then a clean restart.
    start = 1'b1; pat = 8'b1011_0010; len = 4'd8; rep = 1'b0;
    exp_q.push_back(4'b1110); exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1110); exp_q.push_back(4'b1110);
    @(negedge cp); start = 1'b0;
    repeat (3) @(negedge cp);
    #2 rd = 1'b1;
    #1 check("async_reset", int'({x, x_vld, busy, done}), 0);
    check("async_reset_bits_seen", exp_q.size(), 0);
    exp_q.delete();
    @(posedge cp); #2 rd = 1'b0;
    @(negedge cp);
    run_pass(8'b1011_0010, 4'd8, 1'b0, 0);

    // Randomized passes, including back-to-back starts and mid-pass stops.
    for (int t = 0; t < 40; t++) begin
      l = 4'($urandom_range(0, 15));
      r = 1'($urandom_range(0, 1));
      n = (l > 4'd8) ? 8 : int'(l);
      m = 0;
      if (r) m = $urandom_range(1, 20);
      else if (n > 0 && $urandom_range(0, 3) == 0) m = $urandom_range(1, n);
      run_pass(8'($urandom), l, r, m);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge cp);
    end

    repeat (4) @(negedge cp);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
